// File: rtl/integrator_ctrl_pkg.sv
// Shared definitions for the integrator saturation supervisor:
// FSM state encoding and a helper that sizes counters for a given limit.
package integrator_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECOVER = 3'd2,
    ST_RUN     = 3'd3,
    ST_SAT     = 3'd4
  } state_e;

  // Width needed to count from 0 up to limit-1; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/sat_up_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones,
// cleared by synchronous reset or by i_clr.
module sat_up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count events, holding at the maximum value instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/integrator_sat_supervisor.sv
// Run-time supervisor for the saturating integrator: clears it at start-up,
// watches the overflow/underflow flags, forces a clear on sustained saturation
// and mutes the downstream data until the integrator has resettled.
module integrator_sat_supervisor
  import integrator_ctrl_pkg::*;
#(
  parameter int LENGTH      = 5,
  parameter int SAT_LIMIT   = 16,
  parameter int CLR_CYCLES  = 4,
  parameter int MUTE_CYCLES = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 EN_I,
  input  logic [LENGTH-1:0]    DATA_I,
  input  logic                 OFDET_I,
  input  logic                 UFDET_I,
  output logic                 INTEG_CLR_O,
  output logic [LENGTH-1:0]    DATA_O,
  output logic                 VALID_O,
  output logic [STATE_W-1:0]   STATE_O,
  output logic [CNT_WIDTH-1:0] EVENT_CNT_O,
  output logic                 FAULT_O
);

  // One phase counter serves both CLEAR and RECOVER, so size it for the longer.
  localparam int PH_MAX = (CLR_CYCLES > MUTE_CYCLES) ? CLR_CYCLES : MUTE_CYCLES;
  localparam int PH_W   = cnt_w(PH_MAX);
  localparam int SAT_W  = cnt_w(SAT_LIMIT);

  localparam logic [PH_W-1:0]  CLR_LAST  = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0]  MUTE_LAST = PH_W'(MUTE_CYCLES - 1);
  localparam logic [SAT_W-1:0] SAT_LAST  = SAT_W'(SAT_LIMIT - 1);

  state_e              r_state;
  logic [PH_W-1:0]     r_phase;
  logic [SAT_W-1:0]    r_sat_cnt;
  logic                r_integ_clr;
  logic [LENGTH-1:0]   r_data;
  logic                r_valid;
  logic                r_fault;

  state_e              w_state_nxt;
  logic [PH_W-1:0]     w_phase_nxt;
  logic [SAT_W-1:0]    w_sat_cnt_nxt;
  logic                w_event_inc;
  logic                w_sat;
  logic                w_live;

  assign w_sat  = OFDET_I | UFDET_I;
  assign w_live = (r_state == ST_RUN) || (r_state == ST_SAT);

  // Next-state and counter update; disable overrides every transition.
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_sat_cnt_nxt = r_sat_cnt;
    w_event_inc   = 1'b0;
    if (!EN_I) begin
      w_state_nxt   = ST_IDLE;
      w_phase_nxt   = '0;
      w_sat_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt   = ST_CLEAR;
          w_phase_nxt   = '0;
          w_sat_cnt_nxt = '0;
        end
        ST_CLEAR: begin
          if (r_phase == CLR_LAST) begin
            w_state_nxt = ST_RECOVER;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        ST_RECOVER: begin
          if (r_phase == MUTE_LAST) begin
            w_state_nxt = ST_RUN;
            w_phase_nxt = '0;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        ST_RUN: begin
          if (w_sat) begin
            w_state_nxt   = ST_SAT;
            w_sat_cnt_nxt = SAT_W'(1);
          end else begin
            w_sat_cnt_nxt = '0;
          end
        end
        ST_SAT: begin
          if (!w_sat) begin
            w_state_nxt   = ST_RUN;
            w_sat_cnt_nxt = '0;
          end else if (r_sat_cnt == SAT_LAST) begin
            // Sustained saturation: force a fresh clear of the integrator.
            w_state_nxt   = ST_CLEAR;
            w_sat_cnt_nxt = '0;
            w_phase_nxt   = '0;
            w_event_inc   = 1'b1;
          end else begin
            w_sat_cnt_nxt = r_sat_cnt + SAT_W'(1);
          end
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_phase_nxt   = '0;
          w_sat_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_sat_cnt   <= '0;
      r_integ_clr <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_sat_cnt   <= w_sat_cnt_nxt;
      // Clear request mirrors the CLEAR state one-for-one.
      r_integ_clr <= (w_state_nxt == ST_CLEAR);
      if (w_live) begin
        r_data  <= DATA_I;
        r_valid <= 1'b1;
      end else begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end
      if (OFDET_I && UFDET_I) begin
        r_fault <= 1'b1;
      end else begin
        r_fault <= r_fault;
      end
    end
  end

  sat_up_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_event_cnt (
    .i_clk (CLK_I),
    .i_rst (RST_I),
    .i_clr (1'b0),
    .i_inc (w_event_inc),
    .o_cnt (EVENT_CNT_O)
  );

  assign INTEG_CLR_O = r_integ_clr;
  assign DATA_O      = r_data;
  assign VALID_O     = r_valid;
  assign STATE_O     = r_state;
  assign FAULT_O     = r_fault;

endmodule

// File: tb/tb_integrator_sat_supervisor.sv
// Directed self-checking bench for integrator_sat_supervisor (default parameters).
module tb_integrator_sat_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] din;
  logic       ofd;
  logic       ufd;
  logic       clr_o;
  logic [4:0] data_o;
  logic       valid_o;
  logic [2:0] state_o;
  logic [7:0] evt_o;
  logic       fault_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  integrator_sat_supervisor dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .EN_I        (en),
    .DATA_I      (din),
    .OFDET_I     (ofd),
    .UFDET_I     (ufd),
    .INTEG_CLR_O (clr_o),
    .DATA_O      (data_o),
    .VALID_O     (valid_o),
    .STATE_O     (state_o),
    .EVENT_CNT_O (evt_o),
    .FAULT_O     (fault_o)
  );

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ofd = 1'b0; ufd = 1'b0; din = 5'h00;
    tick(); tick();
    n_cmp++;
    if ({clr_o, valid_o, state_o, data_o, evt_o, fault_o} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs act=%h exp=0",
               {clr_o, valid_o, state_o, data_o, evt_o, fault_o});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({state_o, clr_o, valid_o} !== 5'b000_0_0) begin
      n_err++;
      $display("FAIL idle_disabled state=%0d clr=%b valid=%b exp 0/0/0", state_o, clr_o, valid_o);
    end
  endtask

  task automatic test_startup();
    en = 1'b1; din = 5'h0A;
    tick(); // edge 0
    n_cmp++;
    if ({state_o, clr_o, valid_o, data_o} !== {3'd1, 1'b1, 1'b0, 5'h00}) begin
      n_err++;
      $display("FAIL start_edge0 state=%0d clr=%b valid=%b data=%h exp 1/1/0/00",
               state_o, clr_o, valid_o, data_o);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({state_o, clr_o} !== {3'd1, 1'b1}) begin
        n_err++;
        $display("FAIL start_clear edge=%0d state=%0d clr=%b exp 1/1", i, state_o, clr_o);
      end
    end
    tick(); // edge 4
    n_cmp++;
    if ({state_o, clr_o} !== {3'd2, 1'b0}) begin
      n_err++;
      $display("FAIL start_recover state=%0d clr=%b exp 2/0", state_o, clr_o);
    end
    for (int i = 5; i <= 11; i++) begin
      tick();
      n_cmp++;
      if ({state_o, valid_o, data_o} !== {3'd2, 1'b0, 5'h00}) begin
        n_err++;
        $display("FAIL start_mute edge=%0d state=%0d valid=%b data=%h exp 2/0/00",
                 i, state_o, valid_o, data_o);
      end
    end
    tick(); // edge 12
    n_cmp++;
    if ({state_o, valid_o} !== {3'd3, 1'b0}) begin
      n_err++;
      $display("FAIL start_run state=%0d valid=%b exp 3/0", state_o, valid_o);
    end
    din = 5'h13;
    tick(); // edge 13
    n_cmp++;
    if ({valid_o, data_o} !== {1'b1, 5'h13}) begin
      n_err++;
      $display("FAIL first_valid valid=%b data=%h exp 1/13", valid_o, data_o);
    end
    din = 5'h1F;
    tick();
    n_cmp++;
    if (data_o !== 5'h1F) begin
      n_err++;
      $display("FAIL data_follow data=%h exp 1f", data_o);
    end
  endtask

  task automatic test_sat_short();
    din = 5'h0F; ofd = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      n_cmp++;
      if ({state_o, valid_o, data_o, clr_o} !== {3'd4, 1'b1, 5'h0F, 1'b0}) begin
        n_err++;
        $display("FAIL sat15 edge=%0d state=%0d valid=%b data=%h clr=%b exp 4/1/0f/0",
                 i, state_o, valid_o, data_o, clr_o);
      end
    end
    ofd = 1'b0;
    tick();
    n_cmp++;
    if ({state_o, evt_o, clr_o} !== {3'd3, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL sat15_release state=%0d evt=%0d clr=%b exp 3/0/0", state_o, evt_o, clr_o);
    end
  endtask

  task automatic test_sat_clear();
    din = 5'h10; ofd = 1'b1;
    for (int i = 1; i <= 15; i++) tick();
    n_cmp++;
    if (state_o !== 3'd4) begin
      n_err++;
      $display("FAIL sat16_pre state=%0d exp 4", state_o);
    end
    tick(); // 16th flagged edge
    n_cmp++;
    if ({state_o, clr_o, evt_o, valid_o, data_o} !== {3'd1, 1'b1, 8'd1, 1'b1, 5'h10}) begin
      n_err++;
      $display("FAIL sat16_clear state=%0d clr=%b evt=%0d valid=%b data=%h exp 1/1/1/1/10",
               state_o, clr_o, evt_o, valid_o, data_o);
    end
    ofd = 1'b0;
    tick();
    n_cmp++;
    if ({state_o, valid_o, data_o} !== {3'd1, 1'b0, 5'h00}) begin
      n_err++;
      $display("FAIL sat16_mute state=%0d valid=%b data=%h exp 1/0/00", state_o, valid_o, data_o);
    end
    for (int i = 0; i < 11; i++) tick();
    n_cmp++;
    if ({state_o, evt_o} !== {3'd3, 8'd1}) begin
      n_err++;
      $display("FAIL sat16_rerun state=%0d evt=%0d exp 3/1", state_o, evt_o);
    end
  endtask

  task automatic test_fault();
    ofd = 1'b1; ufd = 1'b1;
    tick();
    n_cmp++;
    if ({fault_o, state_o} !== {1'b1, 3'd4}) begin
      n_err++;
      $display("FAIL fault_set fault=%b state=%0d exp 1/4", fault_o, state_o);
    end
    ofd = 1'b0; ufd = 1'b0;
    tick();
    n_cmp++;
    if ({fault_o, state_o} !== {1'b1, 3'd3}) begin
      n_err++;
      $display("FAIL fault_hold fault=%b state=%0d exp 1/3", fault_o, state_o);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (fault_o !== 1'b1) begin
      n_err++;
      $display("FAIL fault_sticky fault=%b exp 1", fault_o);
    end
  endtask

  task automatic test_en_low_clear();
    en = 1'b0;
    tick();
    n_cmp++;
    if ({state_o, clr_o, fault_o, evt_o} !== {3'd0, 1'b0, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL en_low_run state=%0d clr=%b fault=%b evt=%0d exp 0/0/1/1",
               state_o, clr_o, fault_o, evt_o);
    end
    tick();
    n_cmp++;
    if ({valid_o, data_o} !== {1'b0, 5'h00}) begin
      n_err++;
      $display("FAIL en_low_mute valid=%b data=%h exp 0/00", valid_o, data_o);
    end
    en = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({state_o, clr_o} !== {3'd1, 1'b1}) begin
      n_err++;
      $display("FAIL en_restart state=%0d clr=%b exp 1/1", state_o, clr_o);
    end
    en = 1'b0;
    tick();
    n_cmp++;
    if ({state_o, clr_o, valid_o, data_o} !== {3'd0, 1'b0, 1'b0, 5'h00}) begin
      n_err++;
      $display("FAIL en_abort_clear state=%0d clr=%b valid=%b data=%h exp 0/0/0/00",
               state_o, clr_o, valid_o, data_o);
    end
    en = 1'b1;
    tick(); // new CLEAR, phase 0
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({state_o, clr_o} !== {3'd1, 1'b1}) begin
        n_err++;
        $display("FAIL full_clear edge=%0d state=%0d clr=%b exp 1/1", i, state_o, clr_o);
      end
    end
    tick();
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_err++;
      $display("FAIL full_clear_recover state=%0d exp 2", state_o);
    end
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (state_o !== 3'd3) begin
      n_err++;
      $display("FAIL full_clear_run state=%0d exp 3", state_o);
    end
  endtask

  task automatic test_reset_in_sat();
    ofd = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    n_cmp++;
    if ({evt_o, state_o} !== {8'd5, 3'd1}) begin
      n_err++;
      $display("FAIL five_clears evt=%0d state=%0d exp 5/1", evt_o, state_o);
    end
    for (int i = 0; i < 13; i++) tick();
    n_cmp++;
    if (state_o !== 3'd4) begin
      n_err++;
      $display("FAIL back_in_sat state=%0d exp 4", state_o);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({clr_o, valid_o, state_o, data_o, evt_o, fault_o} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_in_sat act=%h exp=0",
               {clr_o, valid_o, state_o, data_o, evt_o, fault_o});
    end
    rst = 1'b0; en = 1'b0; ofd = 1'b0;
    tick();
  endtask

  task automatic test_event_saturate();
    en = 1'b1; ofd = 1'b1;
    for (int i = 0; i < 28 * 254 + 1; i++) tick();
    n_cmp++;
    if ({evt_o, state_o} !== {8'd254, 3'd1}) begin
      n_err++;
      $display("FAIL evt_254 evt=%0d state=%0d exp 254/1", evt_o, state_o);
    end
    for (int i = 0; i < 28; i++) tick();
    n_cmp++;
    if ({evt_o, state_o} !== {8'd255, 3'd1}) begin
      n_err++;
      $display("FAIL evt_255 evt=%0d state=%0d exp 255/1", evt_o, state_o);
    end
    for (int i = 0; i < 28; i++) tick();
    n_cmp++;
    if ({evt_o, state_o} !== {8'd255, 3'd1}) begin
      n_err++;
      $display("FAIL evt_hold evt=%0d state=%0d exp 255/1", evt_o, state_o);
    end
    ofd = 1'b0; en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_sat_short();
    test_sat_clear();
    test_fault();
    test_en_low_clear();
    test_reset_in_sat();
    test_event_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
